// File: rtl/bomb_defuse_ctrl_if.sv
// Bus between the game core and its surroundings.
// The player side (switches, arm button, display return) drives the
// requests, and the game core drives the status lines back.
interface bomb_defuse_ctrl_if #(
    parameter int NUM_WIRES = 4
);
    logic                 start;
    logic [2:0]           key;
    logic [NUM_WIRES-1:0] wires;
    logic                 repeatRst;
    logic                 armed;
    logic                 success;
    logic                 fail;
    logic [6:0]           secs_left;
    logic                 tick;

    modport master (
        output start, key, wires, repeatRst,
        input  armed, success, fail, secs_left, tick
    );

    modport slave (
        input  start, key, wires, repeatRst,
        output armed, success, fail, secs_left, tick
    );
endinterface

// File: rtl/bomb_defuse_ctrl.sv
// Game core of the bomb-dismantlement game.
// Arms a countdown, watches the wire switches through a synchronizer, and
// decides win or lose. A wrong cut costs a strike and a time penalty, and
// a second strike ends the round. The display stages pulse repeatRst to
// return the core to idle.
module bomb_defuse_ctrl #(
    parameter int NUM_WIRES  = 4,
    parameter int TICK_DIV   = 1000,
    parameter int COUNT_SECS = 60,
    parameter int PENALTY    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    bomb_defuse_ctrl_if.slave bus
);

    localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [6:0]      SECS_INIT = 7'(COUNT_SECS);
    localparam logic [7:0]      PENALTY_W = 8'(PENALTY);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        SUCCESS,
        FAIL
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [NUM_WIRES-1:0] s1;
    logic [NUM_WIRES-1:0] s2;
    logic [NUM_WIRES-1:0] s3;
    logic [NUM_WIRES-1:0] cut;
    logic [NUM_WIRES-1:0] target;

    logic [2:0]           key_q;
    logic [2:0]           key_next;
    logic [6:0]           secs_q;
    logic [6:0]           secs_next;
    logic [6:0]           secs_penalised;
    logic [7:0]           deduct;
    logic [1:0]           strikes_q;
    logic [1:0]           strikes_next;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     cnt_next;
    logic                 tick_now;

    // Bring the asynchronous switches into the clock domain and keep one extra
    // sample so a falling edge (a fresh cut) can be detected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '1;
            s2 <= '1;
            s3 <= '1;
        end else begin
            s1 <= bus.wires;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Only 1->0 transitions count; re-connecting a wire never raises an event.
    // A key beyond the wire count shifts out to an empty mask, so every cut is wrong.
    assign cut      = s3 & ~s2;
    assign target   = NUM_WIRES'(1) << key_q;
    assign tick_now = (state == ARMED) && (cnt_q == CNT_LAST);

    // Time left after a wrong cut, clamped at zero; a tick in the same cycle costs one more second.
    always_comb begin
        deduct         = PENALTY_W + {7'd0, tick_now};
        secs_penalised = 7'd0;
        if ({1'b0, secs_q} > deduct) begin
            secs_penalised = secs_q - deduct[6:0];
        end
    end

    // Round sequencing: arming, per-cycle cut/tick evaluation in priority order, and end-of-round return.
    always_comb begin
        state_next   = state;
        key_next     = key_q;
        secs_next    = secs_q;
        strikes_next = strikes_q;
        cnt_next     = cnt_q;
        case (state)
            IDLE: begin
                if (bus.start && (&s2)) begin
                    state_next   = ARMED;
                    key_next     = bus.key;
                    secs_next    = SECS_INIT;
                    cnt_next     = '0;
                    strikes_next = 2'd0;
                end
            end
            ARMED: begin
                cnt_next = tick_now ? '0 : cnt_q + CNT_W'(1);
                if ((cut != '0) && (cut == target)) begin
                    state_next = SUCCESS;
                end else if (cut != '0) begin
                    strikes_next = strikes_q + 2'd1;
                    if (strikes_q == 2'd1) begin
                        state_next = FAIL;
                    end else begin
                        secs_next = secs_penalised;
                        if (secs_penalised == 7'd0) begin
                            state_next = FAIL;
                        end
                    end
                end else if (tick_now) begin
                    secs_next = secs_q - 7'd1;
                    if (secs_q == 7'd1) begin
                        state_next = FAIL;
                    end
                end
            end
            SUCCESS, FAIL: begin
                if (bus.repeatRst) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Game state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Round data: latched key, remaining seconds, strike count and the per-second divider.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= 3'd0;
            secs_q    <= 7'd0;
            strikes_q <= 2'd0;
            cnt_q     <= '0;
        end else begin
            key_q     <= key_next;
            secs_q    <= secs_next;
            strikes_q <= strikes_next;
            cnt_q     <= cnt_next;
        end
    end

    assign bus.armed     = (state == ARMED);
    assign bus.success   = (state == SUCCESS);
    assign bus.fail      = (state == FAIL);
    assign bus.secs_left = secs_q;
    assign bus.tick      = tick_now;

endmodule

// File: tb/tb_bomb_defuse_ctrl.sv
// Testbench for bomb_defuse_ctrl.
// Directed scenarios for the game rules, then a long randomized run; every
// cycle the outputs are compared with a round-level reference model.
module tb_bomb_defuse_ctrl;

    localparam int NUM_WIRES  = 4;
    localparam int TICK_DIV   = 4;
    localparam int COUNT_SECS = 5;
    localparam int PENALTY    = 2;

    localparam int MD_IDLE  = 0;
    localparam int MD_ARMED = 1;
    localparam int MD_WON   = 2;
    localparam int MD_LOST  = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int checks   = 0;
    int failures = 0;

    // Reference model: round mode, seconds, strikes, key, cycles spent armed,
    // and the wire samples seen at the last three edges (newest first).
    int                   mMode;
    int                   mSecs;
    int                   mStrikes;
    int                   mKey;
    int                   mCycles;
    logic [NUM_WIRES-1:0] mSamples[$];

    bomb_defuse_ctrl_if #(.NUM_WIRES(NUM_WIRES)) bus ();

    bomb_defuse_ctrl #(
        .NUM_WIRES (NUM_WIRES),
        .TICK_DIV  (TICK_DIV),
        .COUNT_SECS(COUNT_SECS),
        .PENALTY   (PENALTY)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Safety net so the run can never hang.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required finish before it");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [2:0] k,
                                 input logic [NUM_WIRES-1:0] w, input logic rr);
        bus.start     = st;
        bus.key       = k;
        bus.wires     = w;
        bus.repeatRst = rr;
    endtask

    task automatic modelReset();
        mMode    = MD_IDLE;
        mSecs    = 0;
        mStrikes = 0;
        mKey     = 0;
        mCycles  = 0;
        mSamples.delete();
        repeat (3) mSamples.push_back('1);
    endtask

    function automatic int expTick();
        return ((mMode == MD_ARMED) && ((mCycles % TICK_DIV) == TICK_DIV - 1)) ? 1 : 0;
    endfunction

    // One clock edge of the game rules, using the inputs present before the edge.
    task automatic modelStep();
        logic [NUM_WIRES-1:0] seenNow;
        logic [NUM_WIRES-1:0] seenBefore;
        logic [NUM_WIRES-1:0] cutMask;
        logic [NUM_WIRES-1:0] targetMask;
        int                   t;
        seenNow    = mSamples[1];
        seenBefore = mSamples[2];
        cutMask    = seenBefore & ~seenNow;
        targetMask = (mKey < NUM_WIRES) ? (NUM_WIRES'(1) << mKey) : '0;
        case (mMode)
            MD_IDLE: begin
                if (bus.start && (seenNow == '1)) begin
                    mMode    = MD_ARMED;
                    mKey     = int'(bus.key);
                    mSecs    = COUNT_SECS;
                    mStrikes = 0;
                    mCycles  = 0;
                end
            end
            MD_ARMED: begin
                t = expTick();
                mCycles++;
                if (cutMask != '0 && cutMask == targetMask) begin
                    mMode = MD_WON;
                end else if (cutMask != '0) begin
                    mStrikes++;
                    if (mStrikes >= 2) begin
                        mMode = MD_LOST;
                    end else begin
                        mSecs = mSecs - PENALTY - t;
                        if (mSecs <= 0) begin
                            mSecs = 0;
                            mMode = MD_LOST;
                        end
                    end
                end else if (t == 1) begin
                    mSecs = mSecs - 1;
                    if (mSecs == 0) mMode = MD_LOST;
                end
            end
            default: begin
                if (bus.repeatRst) mMode = MD_IDLE;
            end
        endcase
        mSamples.push_front(bus.wires);
        void'(mSamples.pop_back());
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "/armed"},     bus.armed,     (mMode == MD_ARMED) ? 1 : 0);
        checkOutput({tag, "/success"},   bus.success,   (mMode == MD_WON)   ? 1 : 0);
        checkOutput({tag, "/fail"},      bus.fail,      (mMode == MD_LOST)  ? 1 : 0);
        checkOutput({tag, "/secs_left"}, bus.secs_left, mSecs);
        checkOutput({tag, "/tick"},      bus.tick,      expTick());
    endtask

    task automatic runCycle();
        @(posedge clk);
        modelStep();
        #1;
        checkAll("cycle");
    endtask

    // Drops reset between edges and expects everything cleared before the next edge.
    task automatic asyncResetCheck();
        #2;
        rst_n = 1'b0;
        #1;
        modelReset();
        checkAll("async_rst");
        @(posedge clk);
        #1;
        checkAll("in_rst");
        #2;
        rst_n = 1'b1;
    endtask

    task automatic armWith(input logic [2:0] k);
        int n;
        applyStimulus(1'b1, k, bus.wires, 1'b0);
        n = 0;
        do begin
            runCycle();
            n++;
        end while (!bus.armed && n < 8);
        checkOutput("arm", bus.armed, 1);
        applyStimulus(1'b0, k, bus.wires, 1'b0);
    endtask

    initial begin
        int n;
        logic [NUM_WIRES-1:0] w;
        logic [NUM_WIRES-1:0] bitMask;

        modelReset();
        applyStimulus(1'b0, 3'd0, '1, 1'b0);
        #1;
        checkAll("reset");
        #11;
        rst_n = 1'b1;

        // Countdown with no cuts runs out on the fifth tick.
        armWith(3'd2);
        n = 0;
        while (!bus.fail && n < 40) begin
            runCycle();
            n++;
        end
        checkOutput("t2_fail_edges", n, 20);
        checkOutput("t2_secs", bus.secs_left, 0);
        applyStimulus(1'b0, 3'd2, '1, 1'b1);
        runCycle();
        checkOutput("t2_after_rr", bus.fail, 0);
        applyStimulus(1'b0, 3'd2, '1, 1'b0);

        // Cutting the target wins three edges after the change.
        armWith(3'd1);
        applyStimulus(1'b0, 3'd1, 4'b1101, 1'b0);
        n = 0;
        while (!bus.success && n < 10) begin
            runCycle();
            n++;
        end
        checkOutput("t3_latency", n, 3);
        repeat (5) runCycle();
        checkOutput("t3_held", bus.success, 1);
        applyStimulus(1'b0, 3'd1, 4'b1101, 1'b1);
        runCycle();
        checkOutput("t3_rr_armed", bus.armed, 0);
        checkOutput("t3_rr_success", bus.success, 0);
        applyStimulus(1'b0, 3'd1, '1, 1'b0);

        // One wrong cut costs the penalty, a second wrong cut loses.
        armWith(3'd0);
        applyStimulus(1'b0, 3'd0, 4'b0111, 1'b0);
        repeat (3) runCycle();
        checkOutput("t4_secs", bus.secs_left, 3);
        checkOutput("t4_armed", bus.armed, 1);
        applyStimulus(1'b0, 3'd0, 4'b0011, 1'b0);
        n = 0;
        while (!bus.fail && n < 6) begin
            runCycle();
            n++;
        end
        checkOutput("t4_fail_edges", n, 3);
        applyStimulus(1'b0, 3'd0, 4'b0011, 1'b1);
        runCycle();
        applyStimulus(1'b0, 3'd0, '1, 1'b0);

        // Target plus another wire together is a wrong cut; then abort by reset mid-round.
        armWith(3'd0);
        applyStimulus(1'b0, 3'd0, 4'b0110, 1'b0);
        repeat (3) runCycle();
        checkOutput("t5_secs", bus.secs_left, 3);
        checkOutput("t5_success", bus.success, 0);
        checkOutput("t5_armed", bus.armed, 1);
        asyncResetCheck();
        applyStimulus(1'b0, 3'd0, '1, 1'b0);

        // Target cut lands on the same edge as the final tick: the win takes priority.
        armWith(3'd3);
        repeat (17) runCycle();
        applyStimulus(1'b0, 3'd3, 4'b0111, 1'b0);
        repeat (3) runCycle();
        checkOutput("t5_tick_win", bus.success, 1);
        checkOutput("t5_tick_nofail", bus.fail, 0);
        applyStimulus(1'b0, 3'd3, '1, 1'b1);
        runCycle();
        applyStimulus(1'b0, 3'd3, '1, 1'b0);

        // Arming is refused while any wire is cut, and accepted once it is restored.
        applyStimulus(1'b0, 3'd1, 4'b1110, 1'b0);
        repeat (3) runCycle();
        applyStimulus(1'b1, 3'd1, 4'b1110, 1'b0);
        repeat (4) runCycle();
        checkOutput("t6_hold", bus.armed, 0);
        applyStimulus(1'b1, 3'd1, '1, 1'b0);
        n = 0;
        while (!bus.armed && n < 8) begin
            runCycle();
            n++;
        end
        checkOutput("t6_arm_latency", n, 3);
        applyStimulus(1'b0, 3'd1, '1, 1'b0);

        // Randomized play against the model.
        for (int i = 0; i < 2500; i++) begin
            w = bus.wires;
            bitMask = NUM_WIRES'(1) << $urandom_range(0, NUM_WIRES - 1);
            n = $urandom_range(0, 99);
            if (n < 6)       w = w ^ bitMask;
            else if (n < 8)  w = NUM_WIRES'($urandom);
            else if (n < 14) w = '1;
            if ($urandom_range(0, 399) == 0) begin
                asyncResetCheck();
            end
            applyStimulus(($urandom_range(0, 3) == 0), 3'($urandom_range(0, NUM_WIRES - 1)),
                          w, ($urandom_range(0, 5) == 0));
            runCycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
